// File: rtl/alu_pkg.sv
// Shared ALU types and widths: opcode enum, datapath width and shift-amount width.
package alu_pkg;
  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
  localparam int NREQ    = 2;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SLT    = 4'd7,
    OP_SLTU   = 4'd8,
    OP_SRA    = 4'd9,
    OP_PASS_B = 4'd15
  } alu_op_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the result consumer.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][XLEN-1:0] req_operand_a;
  logic [NREQ-1:0][XLEN-1:0] req_operand_b;
  logic [NREQ-1:0][3:0]      req_op;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [XLEN-1:0]           rsp_data;

  modport master (
    output req_valid, req_operand_a, req_operand_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; undefined opcodes return zero.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  logic [SHAMT_W-1:0] shamt;
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      OP_ADD:    y = a + b;
      OP_SUB:    y = a - b;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_SLL:    y = a << shamt;
      OP_SRL:    y = a >> shamt;
      OP_SLT:    y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:   y = {{(XLEN-1){1'b0}}, a < b};
      OP_SRA:    y = $signed(a) >>> shamt;
      OP_PASS_B: y = b;
      default:   y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; the winner's result lands in a single registered response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);
  logic [NREQ-1:0] grant;
  logic            gid;
  logic            accept;
  logic            slot_free;
  logic            last_grant;
  logic [XLEN-1:0] alu_y;
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [XLEN-1:0] rsp_data_q;

  // A drain in the same cycle frees the slot, which keeps one accept per cycle.
  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  always_comb begin
    grant = '0;
    if (!rst && slot_free) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (RR_EN && !last_grant) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign gid           = grant[1];
  assign accept        = |grant;

  alu u_alu (
    .op (bus.req_op[gid]),
    .a  (bus.req_operand_a[gid]),
    .b  (bus.req_operand_b[gid]),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      last_grant  <= 1'b1;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gid;
      rsp_data_q  <= alu_y;
      last_grant  <= gid;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboarded bench for alu_arbiter: round-robin instance plus a fixed-priority instance.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  alu_arbiter_if bif();
  alu_arbiter_if fif();

  alu_arbiter #(.RR_EN(1'b1)) dut    (.clk(clk), .rst(rst), .bus(bif));
  alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(fif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd9:    return $signed(a) >>> b[4:0];
      4'd15:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard: pop on a consumed response, then push for this cycle's accept.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bif.rsp_valid && bif.rsp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id", {31'd0, bif.rsp_id}, {31'd0, e.id});
          chk("sb_data", bif.rsp_data, e.data);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bif.req_valid[i] && bif.req_ready[i]) begin
          exp_t n;
          n.id   = (i == 1);
          n.data = model(bif.req_op[i], bif.req_operand_a[i], bif.req_operand_b[i]);
          sb.push_back(n);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bif.req_op[i]        = op;
    bif.req_operand_a[i] = a;
    bif.req_operand_b[i] = b;
  endtask

  task automatic issue1(input string tag, input int i, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [1:0] onehot;
    onehot = (i == 0) ? 2'b01 : 2'b10;
    set_req(i, op, a, b);
    bif.req_valid = onehot;
    @(negedge clk);
    chk({tag, "_rdy"}, {30'd0, bif.req_ready}, {30'd0, onehot});
    @(posedge clk); #1;
    bif.req_valid = 2'b00;
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, bif.rsp_valid}, 32'd1);
    chk({tag, "_id"}, {31'd0, bif.rsp_id}, (i == 1) ? 32'd1 : 32'd0);
    chk(tag, bif.rsp_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.rsp_ready = 1'b1;
    bif.req_valid = 2'b11;
    set_req(0, 4'd1, 32'd5, 32'd7);
    set_req(1, 4'd9, 32'h8000_0000, 32'd4);
    fif.rsp_ready     = 1'b1;
    fif.req_valid     = 2'b11;
    fif.req_op        = '0;
    fif.req_operand_a = '0;
    fif.req_operand_b = '0;

    // reset with both requesters asserting
    repeat (2) begin
      @(negedge clk);
      chk("rst_rdy", {30'd0, bif.req_ready}, 32'd0);
      chk("rst_rdy_fp", {30'd0, fif.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bif.req_valid = 2'b00;
    fif.req_valid = 2'b00;
    @(negedge clk);
    chk("rst_vld", {31'd0, bif.rsp_valid}, 32'd0);
    chk("rst_data", bif.rsp_data, 32'd0);
    chk("rst_id", {31'd0, bif.rsp_id}, 32'd0);
    @(posedge clk); #1;

    // round-robin conflict, back-to-back accept and drain
    bif.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt", {30'd0, bif.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        chk("rr_vld", {31'd0, bif.rsp_valid}, 32'd1);
        chk("rr_data", bif.rsp_data, (k % 2 == 1) ? 32'hFFFF_FFFE : 32'hF800_0000);
      end
    end
    @(posedge clk); #1;
    bif.req_valid = 2'b00;
    @(negedge clk);
    chk("rr_last", bif.rsp_data, 32'hF800_0000);
    @(negedge clk);
    chk("drain_vld", {31'd0, bif.rsp_valid}, 32'd0);
    chk("drain_data", bif.rsp_data, 32'hF800_0000);
    chk("drain_id", {31'd0, bif.rsp_id}, 32'd1);
    @(posedge clk); #1;

    // fixed-priority instance: requester 0 wins every conflict
    fif.req_op[0] = 4'd0; fif.req_operand_a[0] = 32'd1; fif.req_operand_b[0] = 32'd1;
    fif.req_op[1] = 4'd3; fif.req_operand_a[1] = 32'd8; fif.req_operand_b[1] = 32'd1;
    fif.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fp_gnt", {30'd0, fif.req_ready}, 32'd1);
      if (k > 0) begin
        chk("fp_id", {31'd0, fif.rsp_id}, 32'd0);
        chk("fp_data", fif.rsp_data, 32'd2);
      end
    end
    @(posedge clk); #1;
    fif.req_valid = 2'b00;

    // single request and edge opcodes
    issue1("add_ovf", 0, 4'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000);
    issue1("sltu",    0, 4'd8,  32'd1,         32'hFFFF_FFFF, 32'd1);
    issue1("slt",     0, 4'd7,  32'd1,         32'hFFFF_FFFF, 32'd0);
    issue1("op12",    1, 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    issue1("pass_b",  1, 4'd15, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue1("sll",     0, 4'd5,  32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
    issue1("srl",     1, 4'd6,  32'h8000_0000, 32'd31,        32'd1);
    issue1("or",      0, 4'd3,  32'hA0A0_0000, 32'h0000_0505, 32'hA0A0_0505);

    // backpressure: pending response held for 3 cycles
    set_req(1, 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    bif.req_valid = 2'b10;
    @(negedge clk);
    chk("bp_rdy0", {30'd0, bif.req_ready}, 32'd2);
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;
    set_req(0, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    bif.req_valid = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy", {30'd0, bif.req_ready}, 32'd0);
      chk("bp_vld", {31'd0, bif.rsp_valid}, 32'd1);
      chk("bp_id", {31'd0, bif.rsp_id}, 32'd1);
      chk("bp_data", bif.rsp_data, 32'hFF00_FF00);
    end
    @(posedge clk); #1;
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_go", {30'd0, bif.req_ready}, 32'd1);
    @(posedge clk); #1;
    bif.req_valid = 2'b00;
    @(negedge clk);
    chk("bp_and", bif.rsp_data, 32'hF000_F000);
    chk("bp_and_id", {31'd0, bif.rsp_id}, 32'd0);
    @(posedge clk); #1;

    // reset with a pending response discards it
    set_req(0, 4'd0, 32'd1, 32'd2);
    bif.rsp_ready = 1'b0;
    bif.req_valid = 2'b01;
    @(negedge clk);
    chk("rm_acc", {30'd0, bif.req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rm_rdy", {30'd0, bif.req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bif.req_valid = 2'b00;
    @(negedge clk);
    chk("rm_vld", {31'd0, bif.rsp_valid}, 32'd0);
    chk("rm_data", bif.rsp_data, 32'd0);
    @(posedge clk); #1;

    chk("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-006 req_operand_a  input  2x32  operand A per requester.
REQ-007 req_operand_b  input  2x32  operand B per requester.
REQ-008 req_op  input  2x4  ALU operation selector per requester.
REQ-009 rsp_valid  output  1  registered result valid.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-012 rsp_data  output  32  registered ALU result.

Function
REQ-013 The block SHALL share one combinational ALU between two requesters, with a single-entry registered response slot.
REQ-014 Slot free SHALL be defined as (!rsp_valid || rsp_ready); no grant SHALL be issued while the slot is not free.
REQ-015 Handshake: a request i is accepted in a cycle iff req_valid[i] && req_ready[i]; req_ready SHALL depend combinationally on req_valid, the slot-free term and the priority pointer, and never on request data.
REQ-016 RR_EN=1: with a single valid requester, it SHALL be granted; with both valid, the requester other than last_grant SHALL be granted.
REQ-017 last_grant SHALL update only on an accepted request.
REQ-018 RR_EN=0: requester 0 SHALL win every conflict.
REQ-019 Latency: a request accepted in cycle N SHALL produce rsp_valid=1 in cycle N+1, with rsp_id=i and rsp_data equal to the ALU result of the operands and op captured in cycle N.
REQ-020 Throughput: one accepted request per cycle SHALL be sustained while rsp_ready=1 (back-to-back accept and drain in the same cycle).
REQ-021 When rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_id and rsp_data SHALL hold stable and req_ready SHALL be 2'b00.
REQ-022 When rsp_valid=1, rsp_ready=1 and no request is accepted, rsp_valid SHALL drop to 0 next cycle; rsp_data and rsp_id SHALL hold their last values.
REQ-023 Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT, 8 SLTU, 9 SRA, 15 PASS_B; shifts use operand_b[4:0].
REQ-024 Undefined opcodes (10-14) SHALL complete normally with rsp_data=0; there is no error signalling.
REQ-025 A requester dropping req_valid without acceptance SHALL be legal; nothing is captured.
REQ-026 Starvation bound (RR_EN=1): a continuously valid requester SHALL be accepted within two accepted grants.

Reset
REQ-027 While rst=1, req_ready SHALL be 2'b00.
REQ-028 On rst, rsp_valid, rsp_id and rsp_data SHALL all be 0, and last_grant SHALL be 1 so requester 0 wins the first conflict.
REQ-029 rst asserted mid-operation SHALL discard any pending response without delivering it; no request is accepted in a reset cycle.

Structure
REQ-030 Shared package alu_pkg SHALL hold the 4-bit op type (alu_op_e, values per REQ-023) and the width constants XLEN=32 and SHAMT_W=5.
REQ-031 The existing alu module SHALL be instantiated once as the only sub-module, between the grant mux and the response register.
REQ-032 Arbitration, handshake and the response register SHALL live in alu_arbiter.

Verification
REQ-033 Reset: hold rst for 2 cycles with both req_valid=1 -> req_ready=00 throughout; rsp_valid=0, rsp_data=0, rsp_id=0 after reset.
REQ-034 Single request: req0 ADD 0x7FFFFFFF+1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0x80000000.
REQ-035 Conflict RR: both requesters valid continuously (req0 SUB 5-7, req1 SRA 0x80000000>>4), rsp_ready=1 -> accepts alternate 0,1,0,1; rsp_data alternates 0xFFFFFFFE, 0xF8000000.
REQ-036 Backpressure: rsp_ready=0 for 3 cycles with a pending response -> rsp outputs stable, req_ready=00; on rsp_ready=1 the next request is accepted in the same cycle.
REQ-037 RR_EN=0 conflict: both requesters valid for 4 cycles -> requester 0 is accepted every cycle; requester 1 is never accepted.
REQ-038 Edge ops: SLTU 1<0xFFFFFFFF gives 1; SLT 1<0xFFFFFFFF gives 0; op 12 gives 0; op 15 with b=0xDEADBEEF gives 0xDEADBEEF; rst asserted with a pending response gives rsp_valid=0 next cycle.
